audio_rec_multi: RTL and testbench
==================================

// Module: audio_rec_multi
// PURPOSE
// Parametrised I2S ADC capture-to-SRAM recorder; next generation of the Lab3 mono recorder.
// Shifts DATA_W-bit MSB-first samples from the codec ADC line and writes one word per channel per frame to SRAM.
// Adds stereo capture, selectable ring (loop) mode, full/wrap flags and word-aligned pause/stop.
// Sits between the codec serial interface and the SRAM port mux, alongside the player.
// PARAMETERS
// DATA_W     16  sample bits captured per channel (1..16); word left-aligned on sram_dq, unused LSBs 0
// ADDR_W     20  SRAM address width; capacity 2**ADDR_W words
// CHANNELS   1   1 = left only (adclrck low), 2 = left+right interleaved (L even addr, R odd addr)
// RING_MODE  0   0 = stop when memory full; 1 = wrap to address 0 and keep recording
// PORTS
// aud_bclk     in   1       codec bit clock; all registers update on its FALLING edge
// rst          in   1       synchronous active-high reset
// start        in   1       begin (IDLE/DONE) or resume (PAUSE); level, sampled each cycle
// pause        in   1       request pause at next word boundary
// stop         in   1       request end of recording at next word boundary
// aud_adclrck  in   1       codec ADC L/R clock (0 = left)
// aud_adcdat   in   1       codec ADC serial data, MSB first
// sram_addr    out  ADDR_W  write address
// sram_dq      out  16      write data
// sram_we_n    out  1       write strobe, active low
// sram_ce_n    out  1       chip enable, active low (constant 0 out of reset)
// sram_oe_n    out  1       output enable, active low (constant 1: block only writes)
// sram_ub_n    out  1       upper byte enable (constant 0)
// sram_lb_n    out  1       lower byte enable (constant 0)
// last_rec     out  ADDR_W  next write address latched on stop/full; 0 after start
// busy         out  1       high in WAIT_EDGE/SHIFT/WRITE
// full         out  1       RING_MODE=0: memory filled, recording ended
// wrapped      out  1       RING_MODE=1: write pointer has wrapped at least once
// BEHAVIOUR
// Reset: state IDLE, sram_addr 0, sram_dq 0, we_n 1, ce_n 0, oe_n 1, ub_n/lb_n 0, last_rec 0, busy/full/wrapped 0, pending flags 0.
// lrck_q registers aud_adclrck each cycle; frame edge = aud_adclrck != lrck_q. Channel = aud_adclrck value at edge.
// IDLE: start -> WAIT_EDGE, addr 0, last_rec 0, full/wrapped 0. pause/stop ignored.
// WAIT_EDGE: on edge into an enabled channel (CHANNELS=1: falling lrck only) at cycle N -> SHIFT.
//   stop -> DONE (last_rec=addr); pause -> PAUSE; checked only when no word is in flight.
// SHIFT: cycles N+1..N+DATA_W sample aud_adcdat MSB-first into shift reg; at N+DATA_W -> WRITE.
// WRITE: sram_dq=word<<(16-DATA_W); sram_we_n=0 for exactly one cycle (registered, addr/dq stable
//   that whole cycle); next cycle we_n=1 and addr increments.
// stop/pause seen in SHIFT/WRITE latch pending flags; acted on after WRITE; pending flags clear on use.
// CHANNELS=2: pending stop/pause honoured only after a right-channel write, keeping L/R pairs aligned.
// Priority each cycle: rst > stop > pause > start. start+stop together in IDLE -> stay IDLE.
// Full: write at addr 2**ADDR_W-1: RING_MODE=0 -> DONE, full=1, last_rec=all-ones, addr not incremented;
//   RING_MODE=1 -> addr wraps to 0, wrapped=1, recording continues.
// PAUSE: start -> WAIT_EDGE (addr kept, resumes on next left edge); stop -> DONE, last_rec=addr.
// DONE: outputs hold; start -> as from IDLE. Reset in any state, incl. mid-SHIFT/WRITE, aborts at once to reset values.
// Requirement on codec: bclk cycles per half-frame >= DATA_W+2.
// TESTING
// 1 mono 16b: start, 3 frames L=0xA5A5,0x1234,0xFFFF -> we_n pulses at addr 0,1,2, dq matches, 1-cycle pulses.
// 2 stereo: CHANNELS=2, L=0x1111 R=0x2222 x2 frames, stop after first L -> words 0x1111,0x2222 at 0,1 only; last_rec=2.
// 3 DATA_W=12: sample 0xABC -> sram_dq=0xABC0.
// 4 full: ADDR_W=4, RING_MODE=0, 20 samples -> 16 writes, full=1, last_rec=0xF, DONE; RING_MODE=1 -> addr 0..15,0..3, wrapped=1.
// 5 pause mid-SHIFT, start after 2 frames -> current word written, no writes while paused, next at following addr.
// 6 rst asserted mid-SHIFT -> next cycle all outputs at reset values, no further we_n pulse.

Source files
------------

// File: rtl/audio_rec_multi.sv
// audio_rec_multi: I2S ADC capture-to-SRAM recorder (mono or stereo, stop-on-full or ring mode).
// Each captured DATA_W-bit sample is written as one SRAM word, left-aligned on sram_dq.
// Stereo interleaves left (even address) and right (odd address) words.
// All registers update on the falling edge of aud_bclk.
//
// Ports:
//   aud_bclk          codec bit clock (falling-edge active)
//   rst               synchronous active-high reset
//   start/pause/stop  recorder control levels, sampled every cycle
//   aud_adclrck       codec ADC L/R clock (0 = left)
//   aud_adcdat        codec ADC serial data, MSB first
//   sram_*            SRAM write port (addr, data, active-low strobes)
//   last_rec          next write address latched when recording ends
//   busy              high while armed, shifting or writing
//   full              memory filled and recording ended (stop-on-full mode)
//   wrapped           write pointer has wrapped at least once (ring mode)
module audio_rec_multi #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 20,
  parameter int CHANNELS  = 1,
  parameter int RING_MODE = 0
) (
  input  logic              aud_bclk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic              aud_adclrck,
  input  logic              aud_adcdat,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq,
  output logic              sram_we_n,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n,
  output logic [ADDR_W-1:0] last_rec,
  output logic              busy,
  output logic              full,
  output logic              wrapped
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_EDGE,
    S_SHIFT,
    S_WRITE,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t      state, state_n;
  logic        lrck_q;
  logic [14:0] shreg;
  logic [15:0] word_next;
  logic [4:0]  bit_cnt;
  logic        cur_ch;
  logic        expect_right;
  logic        stop_pend, pause_pend;

  logic        lrck_edge, want_edge, at_top, word_boundary;
  logic        do_start, do_stop_now, begin_shift, hit_full, stop_after_write;
  logic        set_stop, set_pause, clr_pend;

  assign sram_ce_n = 1'b0;
  assign sram_oe_n = 1'b1;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

  assign busy = (state == S_WAIT_EDGE) || (state == S_SHIFT) || (state == S_WRITE);

  assign lrck_edge = (aud_adclrck != lrck_q);
  // In stereo the recorder alternates left/right so every pair lands on an even/odd address pair.
  assign want_edge = lrck_edge && (aud_adclrck == expect_right);
  assign at_top    = (sram_addr == '1);
  // Stop/pause may only take effect once a complete frame (mono word or L/R pair) is stored.
  assign word_boundary = (CHANNELS == 1) || cur_ch;
  assign word_next = {shreg, aud_adcdat};

  always_comb begin
    state_n          = state;
    do_start         = 1'b0;
    do_stop_now      = 1'b0;
    begin_shift      = 1'b0;
    hit_full         = 1'b0;
    stop_after_write = 1'b0;
    set_stop         = 1'b0;
    set_pause        = 1'b0;
    clr_pend         = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start && !stop && !pause) begin
          state_n  = S_WAIT_EDGE;
          do_start = 1'b1;
          clr_pend = 1'b1;
        end
      end
      S_WAIT_EDGE: begin
        if (!expect_right && (stop || stop_pend)) begin
          state_n     = S_DONE;
          do_stop_now = 1'b1;
          clr_pend    = 1'b1;
        end else if (!expect_right && (pause || pause_pend)) begin
          state_n  = S_PAUSE;
          clr_pend = 1'b1;
        end else begin
          // Between the L and R words of a pair, requests are deferred until the R word is stored.
          set_stop  = expect_right && stop;
          set_pause = expect_right && pause;
          if (want_edge) begin
            state_n     = S_SHIFT;
            begin_shift = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        set_stop  = stop;
        set_pause = pause;
        if (bit_cnt == 5'(DATA_W - 1)) state_n = S_WRITE;
      end
      S_WRITE: begin
        if ((RING_MODE == 0) && at_top) begin
          state_n  = S_DONE;
          hit_full = 1'b1;
          clr_pend = 1'b1;
        end else if (word_boundary && (stop || stop_pend)) begin
          state_n          = S_DONE;
          stop_after_write = 1'b1;
          clr_pend         = 1'b1;
        end else if (word_boundary && (pause || pause_pend)) begin
          state_n  = S_PAUSE;
          clr_pend = 1'b1;
        end else begin
          state_n   = S_WAIT_EDGE;
          set_stop  = stop;
          set_pause = pause;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_n     = S_DONE;
          do_stop_now = 1'b1;
        end else if (start && !pause) begin
          state_n = S_WAIT_EDGE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(negedge aud_bclk) begin
    if (rst) begin
      state        <= S_IDLE;
      lrck_q       <= 1'b0;
      shreg        <= '0;
      bit_cnt      <= '0;
      cur_ch       <= 1'b0;
      expect_right <= 1'b0;
      stop_pend    <= 1'b0;
      pause_pend   <= 1'b0;
      sram_addr    <= '0;
      sram_dq      <= '0;
      sram_we_n    <= 1'b1;
      last_rec     <= '0;
      full         <= 1'b0;
      wrapped      <= 1'b0;
    end else begin
      state  <= state_n;
      lrck_q <= aud_adclrck;

      if (set_stop)  stop_pend  <= 1'b1;
      if (set_pause) pause_pend <= 1'b1;
      if (clr_pend) begin
        stop_pend  <= 1'b0;
        pause_pend <= 1'b0;
      end

      if (do_start) begin
        sram_addr    <= '0;
        last_rec     <= '0;
        full         <= 1'b0;
        wrapped      <= 1'b0;
        expect_right <= 1'b0;
      end

      if (do_stop_now) last_rec <= sram_addr;

      if (begin_shift) begin
        bit_cnt <= '0;
        cur_ch  <= aud_adclrck;
      end

      if (state == S_SHIFT) begin
        shreg   <= word_next[14:0];
        bit_cnt <= bit_cnt + 5'd1;
        if (state_n == S_WRITE) begin
          // Older bits shift out the top, leaving the sample left-aligned with zero LSBs.
          sram_dq   <= word_next << (16 - DATA_W);
          sram_we_n <= 1'b0;
        end
      end

      if (state == S_WRITE) begin
        sram_we_n <= 1'b1;
        if (hit_full) begin
          full     <= 1'b1;
          last_rec <= '1;
        end else begin
          sram_addr <= sram_addr + ADDR_W'(1);
          if (at_top) wrapped <= 1'b1;
          if (stop_after_write) last_rec <= sram_addr + ADDR_W'(1);
          expect_right <= (CHANNELS == 2) && !cur_ch;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_rec_multi.sv
// tb_audio_rec_multi: bench for audio_rec_multi.
// Four recorders share one codec stream: 0 = mono 16b stop-on-full, 1 = mono 16b ring,
// 2 = stereo 16b, 3 = mono 12b. Every instance has a 16-word memory.
// The codec plays endless frames of random samples; expected SRAM contents are derived
// from which frames fall inside each recording window.
module tb_audio_rec_multi;
  localparam int HF = 20;  // bclk cycles per half-frame

  logic bclk = 1'b0;
  logic rst  = 1'b1;
  logic lrck = 1'b1;
  logic dat  = 1'b0;

  logic        start_s[4], pause_s[4], stop_s[4];
  logic [3:0]  addr_o[4], last_o[4];
  logic [15:0] dq_o[4];
  logic        we_o[4], ce_o[4], oe_o[4], ub_o[4], lb_o[4], busy_o[4], full_o[4], wrap_o[4];

  logic [15:0] lmem[256], rmem[256];
  int cur_frame = 0, cur_half = 0, cur_bit = 0;
  int n_checks = 0, n_pass = 0;

  typedef struct packed {
    logic [1:0]  inst;
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;
  wr_t obs[$];
  wr_t mon_w;

  always #5 bclk = ~bclk;

  audio_rec_multi #(.DATA_W(16), .ADDR_W(4), .CHANNELS(1), .RING_MODE(0)) u_full (
    .aud_bclk(bclk), .rst(rst), .start(start_s[0]), .pause(pause_s[0]), .stop(stop_s[0]),
    .aud_adclrck(lrck), .aud_adcdat(dat), .sram_addr(addr_o[0]), .sram_dq(dq_o[0]),
    .sram_we_n(we_o[0]), .sram_ce_n(ce_o[0]), .sram_oe_n(oe_o[0]), .sram_ub_n(ub_o[0]),
    .sram_lb_n(lb_o[0]), .last_rec(last_o[0]), .busy(busy_o[0]), .full(full_o[0]), .wrapped(wrap_o[0]));

  audio_rec_multi #(.DATA_W(16), .ADDR_W(4), .CHANNELS(1), .RING_MODE(1)) u_ring (
    .aud_bclk(bclk), .rst(rst), .start(start_s[1]), .pause(pause_s[1]), .stop(stop_s[1]),
    .aud_adclrck(lrck), .aud_adcdat(dat), .sram_addr(addr_o[1]), .sram_dq(dq_o[1]),
    .sram_we_n(we_o[1]), .sram_ce_n(ce_o[1]), .sram_oe_n(oe_o[1]), .sram_ub_n(ub_o[1]),
    .sram_lb_n(lb_o[1]), .last_rec(last_o[1]), .busy(busy_o[1]), .full(full_o[1]), .wrapped(wrap_o[1]));

  audio_rec_multi #(.DATA_W(16), .ADDR_W(4), .CHANNELS(2), .RING_MODE(0)) u_stereo (
    .aud_bclk(bclk), .rst(rst), .start(start_s[2]), .pause(pause_s[2]), .stop(stop_s[2]),
    .aud_adclrck(lrck), .aud_adcdat(dat), .sram_addr(addr_o[2]), .sram_dq(dq_o[2]),
    .sram_we_n(we_o[2]), .sram_ce_n(ce_o[2]), .sram_oe_n(oe_o[2]), .sram_ub_n(ub_o[2]),
    .sram_lb_n(lb_o[2]), .last_rec(last_o[2]), .busy(busy_o[2]), .full(full_o[2]), .wrapped(wrap_o[2]));

  audio_rec_multi #(.DATA_W(12), .ADDR_W(4), .CHANNELS(1), .RING_MODE(0)) u_w12 (
    .aud_bclk(bclk), .rst(rst), .start(start_s[3]), .pause(pause_s[3]), .stop(stop_s[3]),
    .aud_adclrck(lrck), .aud_adcdat(dat), .sram_addr(addr_o[3]), .sram_dq(dq_o[3]),
    .sram_we_n(we_o[3]), .sram_ce_n(ce_o[3]), .sram_oe_n(oe_o[3]), .sram_ub_n(ub_o[3]),
    .sram_lb_n(lb_o[3]), .last_rec(last_o[3]), .busy(busy_o[3]), .full(full_o[3]), .wrapped(wrap_o[3]));

  // Codec: lrck and data change on the rising edge; MSB one bclk after the lrck transition.
  initial begin
    logic [15:0] smp;
    for (int i = 0; i < 256; i++) begin
      lmem[i] = 16'($urandom);
      rmem[i] = 16'($urandom);
    end
    for (int f = 0; f < 2000; f++)
      for (int h = 0; h < 2; h++)
        for (int b = 0; b < HF; b++) begin
          @(posedge bclk);
          cur_frame = f; cur_half = h; cur_bit = b;
          if (b == 0) lrck = (h == 1);
          smp = (h == 1) ? rmem[f % 256] : lmem[f % 256];
          dat = (b >= 1 && b <= 16) ? smp[16 - b] : 1'b0;
        end
  end

  // Every cycle with a low write strobe is logged as one write.
  always @(posedge bclk) begin
    for (int i = 0; i < 4; i++)
      if (we_o[i] === 1'b0) begin
        mon_w.inst = 2'(i);
        mon_w.a    = addr_o[i];
        mon_w.d    = dq_o[i];
        obs.push_back(mon_w);
      end
  end

  task automatic wait_phase(input int h, input int b);
    int cnt = 0;
    do begin
      @(posedge bclk); #1;
      cnt++;
    end while (!(cur_half == h && cur_bit == b) && cnt < 200);
    if (!(cur_half == h && cur_bit == b)) begin
      n_checks++;
      $display("FAIL phase_wait: got half %0d bit %0d, required half %0d bit %0d", cur_half, cur_bit, h, b);
    end
  endtask

  task automatic pulse(input int which, input int i);
    if (which == 0) start_s[i] = 1'b1; else if (which == 1) pause_s[i] = 1'b1; else stop_s[i] = 1'b1;
    @(posedge bclk); #1;
    start_s[i] = 1'b0; pause_s[i] = 1'b0; stop_s[i] = 1'b0;
  endtask

  task automatic test_reset;
    logic [30:0] got;
    for (int i = 0; i < 4; i++) begin
      got = {addr_o[i], dq_o[i], we_o[i], ce_o[i], oe_o[i], ub_o[i], lb_o[i], last_o[i], busy_o[i], full_o[i], wrap_o[i]};
      n_checks++;
      if (got !== {4'h0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0})
        $display("FAIL reset_outputs[%0d]: got %h required %h", i, got,
                 {4'h0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0});
      else n_pass++;
    end
  endtask

  // Mono 16b (inst 0) and 12b (inst 3) record the same frames, then stop mid-word.
  task automatic test_mono;
    int f0, k, j0, j3;
    logic [15:0] e0[$], e3[$];
    k = $urandom_range(4, 6);
    wait_phase(1, 5);
    f0 = cur_frame;
    lmem[(f0 + 1) % 256] = 16'hA5A5;
    lmem[(f0 + 2) % 256] = 16'h1234;
    lmem[(f0 + 3) % 256] = 16'hFFFF;
    lmem[(f0 + 4) % 256] = 16'hABC0 | 16'($urandom_range(0, 15));
    for (int n = 1; n <= k; n++) begin
      e0.push_back(lmem[(f0 + n) % 256]);
      e3.push_back(lmem[(f0 + n) % 256] & 16'hFFF0);
    end
    obs.delete();
    start_s[3] = 1'b1;
    pulse(0, 0);
    repeat (k) wait_phase(0, 5);
    stop_s[3] = 1'b1;
    pulse(2, 0);
    wait_phase(0, 2);
    j0 = 0; j3 = 0;
    foreach (obs[n]) begin
      if (obs[n].inst == 2'd0) begin
        if (j0 < k) begin
          n_checks++;
          if (obs[n].a !== 4'(j0) || obs[n].d !== e0[j0])
            $display("FAIL mono_write[%0d]: got addr %0h dq %h, required addr %0h dq %h", j0, obs[n].a, obs[n].d, j0, e0[j0]);
          else n_pass++;
        end
        j0++;
      end else if (obs[n].inst == 2'd3) begin
        if (j3 < k) begin
          n_checks++;
          if (obs[n].a !== 4'(j3) || obs[n].d !== e3[j3])
            $display("FAIL w12_write[%0d]: got addr %0h dq %h, required addr %0h dq %h", j3, obs[n].a, obs[n].d, j3, e3[j3]);
          else n_pass++;
        end
        j3++;
      end
    end
    n_checks++;
    if (j0 != k) $display("FAIL mono_count: got %0d required %0d", j0, k); else n_pass++;
    n_checks++;
    if (j3 != k) $display("FAIL w12_count: got %0d required %0d", j3, k); else n_pass++;
    n_checks++;
    if (last_o[0] !== 4'(k) || last_o[3] !== 4'(k))
      $display("FAIL mono_last_rec: got %0h/%0h required %0h", last_o[0], last_o[3], k);
    else n_pass++;
    n_checks++;
    if (busy_o[0] !== 1'b0 || full_o[0] !== 1'b0)
      $display("FAIL mono_done_flags: got busy %b full %b required 0 0", busy_o[0], full_o[0]);
    else n_pass++;
  endtask

  // Stereo: stop during a left word still stores that frame's right word.
  task automatic test_stereo;
    int f0, kp, j;
    logic [15:0] e[$];
    kp = $urandom_range(1, 3);
    wait_phase(1, 5);
    f0 = cur_frame;
    for (int p = 1; p <= kp; p++) begin
      e.push_back(lmem[(f0 + p) % 256]);
      e.push_back(rmem[(f0 + p) % 256]);
    end
    obs.delete();
    pulse(0, 2);
    repeat (kp) wait_phase(0, 5);
    pulse(2, 2);
    wait_phase(0, 2);
    j = 0;
    foreach (obs[n]) if (obs[n].inst == 2'd2) begin
      if (j < 2 * kp) begin
        n_checks++;
        if (obs[n].a !== 4'(j) || obs[n].d !== e[j])
          $display("FAIL stereo_write[%0d]: got addr %0h dq %h, required addr %0h dq %h", j, obs[n].a, obs[n].d, j, e[j]);
        else n_pass++;
      end
      j++;
    end
    n_checks++;
    if (j != 2 * kp) $display("FAIL stereo_count: got %0d required %0d", j, 2 * kp); else n_pass++;
    n_checks++;
    if (last_o[2] !== 4'(2 * kp) || busy_o[2] !== 1'b0)
      $display("FAIL stereo_last_rec: got %0h busy %b required %0h busy 0", last_o[2], busy_o[2], 2 * kp);
    else n_pass++;
  endtask

  // 20 frames into a 16-word memory: inst 0 stops full, inst 1 wraps.
  task automatic test_full;
    int f0, j0, j1;
    wait_phase(1, 5);
    f0 = cur_frame;
    obs.delete();
    start_s[1] = 1'b1;
    pulse(0, 0);
    repeat (20) wait_phase(0, 5);
    pulse(2, 1);
    wait_phase(0, 2);
    j0 = 0; j1 = 0;
    foreach (obs[n]) begin
      if (obs[n].inst == 2'd0) begin
        if (j0 < 16) begin
          n_checks++;
          if (obs[n].a !== 4'(j0) || obs[n].d !== lmem[(f0 + 1 + j0) % 256])
            $display("FAIL full_write[%0d]: got addr %0h dq %h, required addr %0h dq %h", j0, obs[n].a, obs[n].d, j0, lmem[(f0 + 1 + j0) % 256]);
          else n_pass++;
        end
        j0++;
      end else if (obs[n].inst == 2'd1) begin
        if (j1 < 20) begin
          n_checks++;
          if (obs[n].a !== 4'(j1 % 16) || obs[n].d !== lmem[(f0 + 1 + j1) % 256])
            $display("FAIL ring_write[%0d]: got addr %0h dq %h, required addr %0h dq %h", j1, obs[n].a, obs[n].d, j1 % 16, lmem[(f0 + 1 + j1) % 256]);
          else n_pass++;
        end
        j1++;
      end
    end
    n_checks++;
    if (j0 != 16) $display("FAIL full_count: got %0d required 16", j0); else n_pass++;
    n_checks++;
    if (j1 != 20) $display("FAIL ring_count: got %0d required 20", j1); else n_pass++;
    n_checks++;
    if ({full_o[0], wrap_o[0], busy_o[0], last_o[0]} !== {1'b1, 1'b0, 1'b0, 4'hF})
      $display("FAIL full_flags: got full %b wrapped %b busy %b last %h, required 1 0 0 f", full_o[0], wrap_o[0], busy_o[0], last_o[0]);
    else n_pass++;
    n_checks++;
    if ({full_o[1], wrap_o[1], busy_o[1], last_o[1]} !== {1'b0, 1'b1, 1'b0, 4'h4})
      $display("FAIL ring_flags: got full %b wrapped %b busy %b last %h, required 0 1 0 4", full_o[1], wrap_o[1], busy_o[1], last_o[1]);
    else n_pass++;
  endtask

  // Pause mid-word, sit out two frames, resume, then stop.
  task automatic test_pause;
    int f0, fp, m, j;
    int ef[$];
    m = $urandom_range(1, 3);
    wait_phase(1, 5);
    f0 = cur_frame;
    obs.delete();
    pulse(0, 0);
    repeat (m) wait_phase(0, 5);
    pulse(1, 0);
    fp = cur_frame;
    for (int f = f0 + 1; f <= fp; f++) ef.push_back(f);
    wait_phase(1, 5);
    n_checks++;
    if (busy_o[0] !== 1'b0) $display("FAIL pause_busy: got %b required 0", busy_o[0]); else n_pass++;
    repeat (2) wait_phase(1, 5);
    j = 0;
    foreach (obs[n]) if (obs[n].inst == 2'd0) j++;
    n_checks++;
    if (j != m) $display("FAIL pause_quiet: got %0d writes required %0d", j, m); else n_pass++;
    pulse(0, 0);
    ef.push_back(fp + 3);
    ef.push_back(fp + 4);
    repeat (2) wait_phase(0, 5);
    pulse(2, 0);
    wait_phase(0, 2);
    j = 0;
    foreach (obs[n]) if (obs[n].inst == 2'd0) begin
      if (j < ef.size()) begin
        n_checks++;
        if (obs[n].a !== 4'(j) || obs[n].d !== lmem[ef[j] % 256])
          $display("FAIL pause_write[%0d]: got addr %0h dq %h, required addr %0h dq %h", j, obs[n].a, obs[n].d, j, lmem[ef[j] % 256]);
        else n_pass++;
      end
      j++;
    end
    n_checks++;
    if (j != m + 2 || last_o[0] !== 4'(m + 2))
      $display("FAIL pause_total: got %0d writes last %0h, required %0d writes last %0h", j, last_o[0], m + 2, m + 2);
    else n_pass++;
  endtask

  // Reset while a word is being shifted: outputs clear next cycle and that word is never written.
  task automatic test_rst_midshift;
    logic [30:0] got;
    int j;
    wait_phase(1, 5);
    obs.delete();
    pulse(0, 0);
    repeat (2) wait_phase(0, 5);
    wait_phase(0, 8);
    rst = 1'b1;
    @(negedge bclk);
    @(posedge bclk); #1;
    got = {addr_o[0], dq_o[0], we_o[0], ce_o[0], oe_o[0], ub_o[0], lb_o[0], last_o[0], busy_o[0], full_o[0], wrap_o[0]};
    n_checks++;
    if (got !== {4'h0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0})
      $display("FAIL rst_midshift_outputs: got %h required %h", got,
               {4'h0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0});
    else n_pass++;
    rst = 1'b0;
    repeat (2) wait_phase(0, 5);
    j = 0;
    foreach (obs[n]) if (obs[n].inst == 2'd0) j++;
    n_checks++;
    if (j != 1) $display("FAIL rst_midshift_writes: got %0d required 1", j); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      start_s[i] = 1'b0;
      pause_s[i] = 1'b0;
      stop_s[i]  = 1'b0;
    end
    rst = 1'b1;
    repeat (4) @(posedge bclk);
    #1;
    test_reset;
    rst = 1'b0;
    test_mono;
    test_stereo;
    test_full;
    test_pause;
    test_rst_midshift;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
